// File: rtl/test_monitor_pkg.sv
// test_monitor_pkg: shared types and helpers for the test_monitor regression checker.
//   state_t      - run sequencer states (IDLE, RUN, EVAL, DONE)
//   check_slot_t - one configured check: watched address, expected value, compare mask
//   slot_fail()  - judges one slot at the end of a run
// Slot fields are stored at fixed maximum widths so the struct can live in a package;
// the top zero-extends its parametrised buses, so ADDR_W and DATA_W must not exceed 32.
package test_monitor_pkg;

  localparam int unsigned TM_MAX_ADDR_W = 32;
  localparam int unsigned TM_MAX_DATA_W = 32;

  typedef logic [TM_MAX_ADDR_W-1:0] tm_addr_t;
  typedef logic [TM_MAX_DATA_W-1:0] tm_data_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    EVAL = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef struct packed {
    tm_addr_t addr;
    tm_data_t exp;
    tm_data_t mask;
  } check_slot_t;

  // A slot with mask 0 is disabled and never fails. An enabled slot fails if it was
  // never written, if its last value differs under the mask, or if its sticky bit is set.
  function automatic logic slot_fail(input check_slot_t slot, input tm_data_t shadow,
                                     input logic seen, input logic sticky);
    logic enabled;
    logic wrong;
    enabled = (slot.mask != '0);
    wrong   = (((shadow ^ slot.exp) & slot.mask) != '0);
    return enabled & (~seen | wrong | sticky);
  endfunction

endpackage

// File: rtl/test_monitor_slot.sv
// test_monitor_slot: one check slot of test_monitor.
//   ph2, reset     - clock / asynchronous active-high reset
//   clear          - clears shadow, seen and sticky (start of a run)
//   run            - capture enable (run in progress)
//   bus_we/addr/data - memory write bus, zero-extended to package widths
//   watch_addr     - address this slot watches
//   exp_val, mask_val - only present with TEST_MONITOR_STICKY_EN, used by the sticky bit
//   shadow, seen, sticky - last value written, written-at-least-once, any bad write
// Optional feature macro: TEST_MONITOR_STICKY_EN.
module test_monitor_slot
  import test_monitor_pkg::*;
(
  input  logic     ph2,
  input  logic     reset,
  input  logic     clear,
  input  logic     run,
  input  logic     bus_we,
  input  tm_addr_t bus_addr,
  input  tm_data_t bus_data,
  input  tm_addr_t watch_addr,
`ifdef TEST_MONITOR_STICKY_EN
  input  tm_data_t exp_val,
  input  tm_data_t mask_val,
`endif
  output tm_data_t shadow,
  output logic     seen,
  output logic     sticky
);

  logic     hit;
  tm_data_t shadow_d, shadow_q;
  logic     seen_d, seen_q;

  assign hit = run & bus_we & (bus_addr == watch_addr);

  always_comb begin
    shadow_d = shadow_q;
    seen_d   = seen_q;
    if (clear) begin
      shadow_d = '0;
      seen_d   = 1'b0;
    end else if (hit) begin
      shadow_d = bus_data;
      seen_d   = 1'b1;
    end
  end

  always_ff @(posedge ph2 or posedge reset) begin
    if (reset) begin
      shadow_q <= '0;
      seen_q   <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      seen_q   <= seen_d;
    end
  end

  assign shadow = shadow_q;
  assign seen   = seen_q;

`ifdef TEST_MONITOR_STICKY_EN
  logic sticky_d, sticky_q;

  always_comb begin
    sticky_d = sticky_q;
    if (clear) begin
      sticky_d = 1'b0;
    end else if (hit && (((bus_data ^ exp_val) & mask_val) != '0)) begin
      sticky_d = 1'b1;
    end
  end

  always_ff @(posedge ph2 or posedge reset) begin
    if (reset) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky = sticky_q;
`else
  assign sticky = 1'b0;
`endif

endmodule

// File: rtl/test_monitor.sv
// test_monitor: regression checker watching the memory-write bus.
// Records the last value written to each of N_CHECKS configured addresses; a run ends on a
// write to end_addr or after run_limit cycles, then per-slot pass/fail is reported.
//   ph2, reset         - clock (bus sampled on rising edge) / async active-high reset
//   bus_addr/data/we   - memory write bus
//   cfg_we/idx/addr/exp/mask - check table write port (IDLE or DONE only)
//   end_addr, run_limit - run terminators (run_limit 0 = no timeout)
//   start              - begin a run
//   busy, done, pass, timeout, fail_mask, cycles - status and results
// Optional feature macro: TEST_MONITOR_STICKY_EN (sticky per-slot mismatch bit).
module test_monitor
  import test_monitor_pkg::*;
#(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned N_CHECKS = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                ph2,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   bus_addr,
  input  logic [DATA_W-1:0]   bus_data,
  input  logic                bus_we,
  input  logic                cfg_we,
  input  logic [((N_CHECKS > 1) ? $clog2(N_CHECKS) : 1)-1:0] cfg_idx,
  input  logic [ADDR_W-1:0]   cfg_addr,
  input  logic [DATA_W-1:0]   cfg_exp,
  input  logic [DATA_W-1:0]   cfg_mask,
  input  logic [ADDR_W-1:0]   end_addr,
  input  logic [CNT_W-1:0]    run_limit,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                timeout,
  output logic [N_CHECKS-1:0] fail_mask,
  output logic [CNT_W-1:0]    cycles
);

  state_t              state_d, state_q;
  logic [CNT_W-1:0]    cycles_d, cycles_q;
  logic                timeout_d, timeout_q;
  logic                pass_d, pass_q;
  logic [N_CHECKS-1:0] fail_mask_d, fail_mask_q;
  check_slot_t         table_d [N_CHECKS];
  check_slot_t         table_q [N_CHECKS];

  logic                start_run;
  logic                end_hit;
  logic                limit_hit;
  tm_addr_t            bus_addr_x;
  tm_data_t            bus_data_x;
  tm_data_t            shadow [N_CHECKS];
  logic [N_CHECKS-1:0] seen;
  logic [N_CHECKS-1:0] sticky;
  logic [N_CHECKS-1:0] slot_fail_vec;

  assign bus_addr_x = tm_addr_t'(bus_addr);
  assign bus_data_x = tm_data_t'(bus_data);

  // An end write in the same cycle as the limit wins, so the limit is masked by it.
  assign end_hit   = (state_q == RUN) && bus_we && (bus_addr == end_addr);
  assign limit_hit = (state_q == RUN) && (run_limit != '0) &&
                     (cycles_q == run_limit - CNT_W'(1)) && !end_hit;

  for (genvar g = 0; g < N_CHECKS; g++) begin : g_slot
    test_monitor_slot u_slot (
      .ph2       (ph2),
      .reset     (reset),
      .clear     (start_run),
      .run       (state_q == RUN),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr_x),
      .bus_data  (bus_data_x),
      .watch_addr(table_q[g].addr),
`ifdef TEST_MONITOR_STICKY_EN
      .exp_val   (table_q[g].exp),
      .mask_val  (table_q[g].mask),
`endif
      .shadow    (shadow[g]),
      .seen      (seen[g]),
      .sticky    (sticky[g])
    );
  end

  always_comb begin
    slot_fail_vec = '0;
    for (int unsigned i = 0; i < N_CHECKS; i++) begin
      slot_fail_vec[i] = slot_fail(table_q[i], shadow[i], seen[i], sticky[i]);
    end
  end

  always_comb begin
    state_d     = state_q;
    cycles_d    = cycles_q;
    timeout_d   = timeout_q;
    pass_d      = pass_q;
    fail_mask_d = fail_mask_q;
    table_d     = table_q;
    start_run   = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (cfg_we && (32'(cfg_idx) < N_CHECKS)) begin
          table_d[cfg_idx] = '{addr: tm_addr_t'(cfg_addr),
                               exp:  tm_data_t'(cfg_exp),
                               mask: tm_data_t'(cfg_mask)};
        end
        if (start) begin
          state_d     = RUN;
          start_run   = 1'b1;
          cycles_d    = '0;
          timeout_d   = 1'b0;
          pass_d      = 1'b0;
          fail_mask_d = '0;
        end
      end
      RUN: begin
        cycles_d = (cycles_q == '1) ? cycles_q : cycles_q + CNT_W'(1);
        if (end_hit) begin
          state_d = EVAL;
        end else if (limit_hit) begin
          timeout_d = 1'b1;
          state_d   = EVAL;
        end
      end
      EVAL: begin
        fail_mask_d = slot_fail_vec;
        pass_d      = !timeout_q && (slot_fail_vec == '0);
        state_d     = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ph2 or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cycles_q    <= '0;
      timeout_q   <= 1'b0;
      pass_q      <= 1'b0;
      fail_mask_q <= '0;
      table_q     <= '{default: '0};
    end else begin
      state_q     <= state_d;
      cycles_q    <= cycles_d;
      timeout_q   <= timeout_d;
      pass_q      <= pass_d;
      fail_mask_q <= fail_mask_d;
      table_q     <= table_d;
    end
  end

  assign busy      = (state_q == RUN) || (state_q == EVAL);
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign timeout   = timeout_q;
  assign fail_mask = fail_mask_q;
  assign cycles    = cycles_q;

endmodule

// File: tb/tb_test_monitor.sv
// tb_test_monitor: directed bench for test_monitor with a write-log reference model.
// Optional feature macro: TEST_MONITOR_STICKY_EN (changes sticky-related expectations).
module tb_test_monitor;

  logic        ph2 = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] bus_addr = '0;
  logic [7:0]  bus_data = '0;
  logic        bus_we = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [15:0] cfg_addr = '0;
  logic [7:0]  cfg_exp = '0;
  logic [7:0]  cfg_mask = '0;
  logic [15:0] end_addr = 16'h00FF;
  logic [15:0] run_limit = 16'd60;
  logic        start = 1'b0;
  logic        busy, done, pass, timeout;
  logic [3:0]  fail_mask;
  logic [15:0] cycles;

  int n_checks = 0;
  int n_errors = 0;

  test_monitor #(
    .ADDR_W  (16),
    .DATA_W  (8),
    .N_CHECKS(4),
    .CNT_W   (16)
  ) dut (
    .ph2      (ph2),
    .reset    (reset),
    .bus_addr (bus_addr),
    .bus_data (bus_data),
    .bus_we   (bus_we),
    .cfg_we   (cfg_we),
    .cfg_idx  (cfg_idx),
    .cfg_addr (cfg_addr),
    .cfg_exp  (cfg_exp),
    .cfg_mask (cfg_mask),
    .end_addr (end_addr),
    .run_limit(run_limit),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .timeout  (timeout),
    .fail_mask(fail_mask),
    .cycles   (cycles)
  );

  always #5 ph2 = ~ph2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: the run is a log of bus writes; results are judged from the log.
  typedef struct {
    int a;
    int d;
  } wr_t;

  int   m_addr [4];
  int   m_exp  [4];
  int   m_mask [4];
  bit   m_run  = 0;
  bit   m_eval = 0;
  int   m_cyc  = 0;
  bit   e_done = 0;
  bit   e_pass = 0;
  bit   e_to   = 0;
  logic [3:0] e_fail = '0;
  wr_t  log_q[$];

  initial begin
    bit seen_w;
    bit bad_w;
    int last_w;
    for (int i = 0; i < 4; i++) begin
      m_addr[i] = 0; m_exp[i] = 0; m_mask[i] = 0;
    end
    forever begin
      @(posedge ph2 or posedge reset);
      if (reset) begin
        for (int i = 0; i < 4; i++) begin
          m_addr[i] = 0; m_exp[i] = 0; m_mask[i] = 0;
        end
        m_run = 0; m_eval = 0; m_cyc = 0;
        e_done = 0; e_pass = 0; e_to = 0; e_fail = '0;
        log_q.delete();
      end else if (m_eval) begin
        m_eval = 0;
        e_done = 1;
        for (int i = 0; i < 4; i++) begin
          seen_w = 0; bad_w = 0; last_w = 0;
          foreach (log_q[k]) begin
            if (log_q[k].a == m_addr[i]) begin
              seen_w = 1;
              last_w = log_q[k].d;
              if (((log_q[k].d ^ m_exp[i]) & m_mask[i]) != 0) bad_w = 1;
            end
          end
`ifndef TEST_MONITOR_STICKY_EN
          bad_w = 0;
`endif
          e_fail[i] = (m_mask[i] != 0) &&
                      (!seen_w || (((last_w ^ m_exp[i]) & m_mask[i]) != 0) || bad_w);
        end
        e_pass = !e_to && (e_fail == 4'b0000);
      end else if (m_run) begin
        if (m_cyc < 65535) m_cyc = m_cyc + 1;
        if (bus_we) log_q.push_back('{int'(bus_addr), int'(bus_data)});
        if (bus_we && bus_addr == end_addr) begin
          m_run = 0; m_eval = 1;
        end else if (run_limit != 0 && m_cyc == int'(run_limit)) begin
          e_to = 1; m_run = 0; m_eval = 1;
        end
      end else begin
        if (cfg_we) begin
          m_addr[cfg_idx] = int'(cfg_addr);
          m_exp[cfg_idx]  = int'(cfg_exp);
          m_mask[cfg_idx] = int'(cfg_mask);
        end
        if (start) begin
          m_run = 1; m_cyc = 0;
          e_done = 0; e_pass = 0; e_to = 0; e_fail = '0;
          log_q.delete();
        end
      end
    end
  end

  // Every cycle, away from the active edge, outputs must match the model.
  initial begin
    forever begin
      @(negedge ph2);
      check("busy",      32'(busy),      32'(m_run | m_eval));
      check("done",      32'(done),      32'(e_done));
      check("pass",      32'(pass),      32'(e_pass));
      check("timeout",   32'(timeout),   32'(e_to));
      check("fail_mask", 32'(fail_mask), 32'(e_fail));
      check("cycles",    32'(cycles),    32'(m_cyc));
    end
  end

  // Stimulus tasks are entered at a falling edge and return at a falling edge.
  task automatic cfg_slot(input int idx, input int a, input int e, input int m);
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_addr = 16'(a); cfg_exp = 8'(e); cfg_mask = 8'(m);
    @(negedge ph2);
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge ph2);
    start = 1'b0;
  endtask

  task automatic bus_wr(input int a, input int d);
    bus_we = 1'b1; bus_addr = 16'(a); bus_data = 8'(d);
    @(negedge ph2);
    bus_we = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done) return;
      @(negedge ph2);
    end
    check({name, " done_wait"}, 32'(done), 32'd1);
  endtask

  task automatic expect_result(input string name, input int p, input int to,
                               input int fm, input int cyc);
    #1;
    check({name, " pass"},      32'(pass),      32'(p));
    check({name, " timeout"},   32'(timeout),   32'(to));
    check({name, " fail_mask"}, 32'(fail_mask), 32'(fm));
    check({name, " cycles"},    32'(cycles),    32'(cyc));
    @(negedge ph2);
  endtask

  initial begin
    repeat (2) @(negedge ph2);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst fail_mask", 32'(fail_mask), 32'd0);
    reset = 1'b0;
    @(negedge ph2);

    // 1: matching write then end write
    cfg_slot(0, 'h0040, 'h42, 'hFF);
    pulse_start();
    bus_wr('h0040, 'h42);
    bus_wr('h00FF, 'h00);
    wait_done("t1", 10);
    expect_result("t1", 1, 0, 'b0001 & 0, 2);

    // 2: wrong value
    pulse_start();
    bus_wr('h0040, 'h41);
    bus_wr('h00FF, 'h00);
    wait_done("t2", 10);
    expect_result("t2", 0, 0, 'b0001, 2);

    // 3: no end write, timeout at 60 cycles; slots 0 and 1 never written
    cfg_slot(1, 'h0050, 'h05, 'h0F);
    pulse_start();
    wait_done("t3", 100);
    expect_result("t3", 0, 1, 'b0011, 60);

    // 4: masked compare passes; mask-0 slot never fails
    cfg_slot(2, 'h0060, 'h11, 'h00);
    pulse_start();
    bus_wr('h0050, 'hA5);
    bus_wr('h0040, 'h42);
    bus_wr('h0060, 'h99);
    bus_wr('h00FF, 'h01);
    wait_done("t4", 10);
    expect_result("t4", 1, 0, 'b0000, 4);

    // 5: bad write overwritten by good one
    pulse_start();
    bus_wr('h0040, 'h00);
    bus_wr('h0040, 'h42);
    bus_wr('h0050, 'h05);
    bus_wr('h00FF, 'h00);
    wait_done("t5", 10);
`ifdef TEST_MONITOR_STICKY_EN
    expect_result("t5", 0, 0, 'b0001, 4);
`else
    expect_result("t5", 1, 0, 'b0000, 4);
`endif

    // 6: end write and limit in the same cycle, end write wins
    run_limit = 16'd3;
    pulse_start();
    bus_wr('h0040, 'h42);
    bus_wr('h0050, 'h05);
    bus_wr('h00FF, 'h00);
    wait_done("t6", 10);
    expect_result("t6", 1, 0, 'b0000, 3);
    run_limit = 16'd60;

    // 7: slot watching end_addr; cfg and start during RUN are ignored
    cfg_slot(3, 'h00FF, 'h77, 'hFF);
    pulse_start();
    bus_wr('h0040, 'h42);
    bus_wr('h0050, 'h05);
    cfg_slot(0, 'h0040, 'h99, 'hFF);
    pulse_start();
    bus_wr('h00FF, 'h77);
    wait_done("t7", 10);
    expect_result("t7", 1, 0, 'b0000, 5);

    pulse_start();
    bus_wr('h0040, 'h42);
    bus_wr('h0050, 'h05);
    bus_wr('h00FF, 'h70);
    wait_done("t7b", 10);
    expect_result("t7b", 0, 0, 'b1000, 3);

    // 8: asynchronous reset mid-run, then a run with an empty table
    pulse_start();
    bus_wr('h0040, 'h42);
    #2 reset = 1'b1;
    #1;
    check("t8 busy", 32'(busy), 32'd0);
    check("t8 done", 32'(done), 32'd0);
    check("t8 fail_mask", 32'(fail_mask), 32'd0);
    @(negedge ph2);
    reset = 1'b0;
    @(negedge ph2);
    pulse_start();
    bus_wr('h00FF, 'h00);
    wait_done("t8", 10);
    expect_result("t8", 1, 0, 'b0000, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
